// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the fetch sequencer: FSM states, PC width and the
// absolute branch target table indexed by the decoder's PCTarg field.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

    localparam int PC_W = 10;

    localparam logic [PC_W-1:0] BRANCH_TARGETS [16] = '{
        10'd0,   10'd16,  10'd48,  10'd100,
        10'd200, 10'd300, 10'd400, 10'd500,
        10'd600, 10'd700, 10'd800, 10'd900,
        10'd1000, 10'd1020, 10'd1023, 10'd37
    };

endpackage

// File: rtl/inst_fetch_pc_lut.sv
// Combinational branch target lookup: maps the 4-bit PCTarg index onto a
// full absolute program address.
module pc_lut
    import inst_fetch_pkg::*;
#(
    parameter int PW = PC_W
) (
    input  logic [3:0]    PCTarg,
    output logic [PW-1:0] Target
);

    // Direct table read, no registering so the jump lands with no delay slot.
    always_comb begin
        Target = PW'(BRANCH_TARGETS[PCTarg]);
    end

endmodule

// File: rtl/inst_fetch.sv
// Program counter and fetch sequencer (IDLE/ARM/RUN/HALT) with Start/Done
// harness handshake. Optional RUN-cycle counter under INST_FETCH_CYCLE_CNT_EN.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int PW = PC_W
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Branch,
    input  logic [3:0]    PCTarg,
    input  logic          Ack,
    output logic [PW-1:0] ProgCtr,
    output logic          Running,
    output logic          Done,
    output logic [15:0]   CycleCnt
);

    fetch_state_t  state_r, state_nxt_s;
    logic [PW-1:0] pc_r, pc_nxt_s;
    logic [PW-1:0] target_s;
    logic          done_r, done_nxt_s;
    logic          running_r;

    pc_lut #(.PW(PW)) u_pc_lut (
        .PCTarg (PCTarg),
        .Target (target_s)
    );

    // Next-state, next-PC and Done; Start outranks Ack, which outranks Branch.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        done_nxt_s  = done_r;
        case (state_r)
            IDLE: begin
                pc_nxt_s = {PW{1'b0}};
                if (Start) begin
                    state_nxt_s = ARM;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ARM: begin
                pc_nxt_s   = {PW{1'b0}};
                done_nxt_s = 1'b0;
                if (Start) begin
                    state_nxt_s = ARM;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            RUN: begin
                if (Start) begin
                    state_nxt_s = ARM;
                    pc_nxt_s    = {PW{1'b0}};
                    done_nxt_s  = 1'b0;
                end else if (Ack) begin
                    state_nxt_s = HALT;
                    done_nxt_s  = 1'b1;
                end else if (Branch) begin
                    pc_nxt_s = target_s;
                end else begin
                    pc_nxt_s = pc_r + {{(PW-1){1'b0}}, 1'b1};
                end
            end
            HALT: begin
                if (Start) begin
                    state_nxt_s = ARM;
                    pc_nxt_s    = {PW{1'b0}};
                    done_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = HALT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                pc_nxt_s    = {PW{1'b0}};
                done_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, PC and status registers; Running is registered from the next state.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r   <= IDLE;
            pc_r      <= {PW{1'b0}};
            done_r    <= 1'b0;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pc_r      <= pc_nxt_s;
            done_r    <= done_nxt_s;
            running_r <= (state_nxt_s == RUN);
        end
    end

    assign ProgCtr = pc_r;
    assign Running = running_r;
    assign Done    = done_r;

`ifdef INST_FETCH_CYCLE_CNT_EN
    logic [15:0] cnt_r, cnt_nxt_s;

    // Saturating count of edges spent in RUN, cleared whenever ARM is entered.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (state_nxt_s == ARM) begin
            cnt_nxt_s = 16'h0000;
        end else if ((state_r == RUN) && (cnt_r != 16'hFFFF)) begin
            cnt_nxt_s = cnt_r + 16'h0001;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Cycle counter register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_r <= 16'h0000;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign CycleCnt = cnt_r;
`else
    assign CycleCnt = 16'h0000;
`endif

endmodule
